// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Instruction prefetch stage. It holds a fetch PC, issues word fetches to the
// instruction memory over a req/ack handshake, and buffers the returned words,
// each tagged with its PC, in a DEPTH-entry FIFO. The FIFO head is presented
// downstream with a valid/ready handshake. REDIRECT flushes the FIFO and
// restarts fetching at the new PC.
//
// Optional feature macro: FETCH_STATS_EN
//   Defined   : adds STAT_FETCHES and STAT_DISCARDS, which are saturating
//               counters of pushes and of discarded instructions.
//   Undefined : those ports and counters are absent.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   CLK, RST        clock (rising edge), async active-low reset
//   REDIRECT        flush and restart fetch at REDIRECT_PC (bits [1:0] ignored)
//   MEM_REQ/ADDR    fetch request and word-aligned address
//   MEM_ACK/RDATA   memory response; ACK may coincide with REQ
//   INST_VALID/INST/INST_PC/INST_READY  downstream head of queue
//   COUNT           occupied entries
//
// State table
//   state | meaning
//   IDLE  | no request outstanding; start one when a slot is free
//   REQ   | request outstanding at MEM_ADDR; data will be pushed
//   DROP  | request outstanding but its data is stale (after REDIRECT)
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       REDIRECT,
  input  logic [31:0]                REDIRECT_PC,
  output logic                       MEM_REQ,
  output logic [31:0]                MEM_ADDR,
  input  logic                       MEM_ACK,
  input  logic [31:0]                MEM_RDATA,
  output logic                       INST_VALID,
  output logic [31:0]                INST,
  output logic [31:0]                INST_PC,
  input  logic                       INST_READY,
  output logic [$clog2(DEPTH):0]     COUNT
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]                STAT_FETCHES,
  output logic [31:0]                STAT_DISCARDS
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];

  logic          push;
  logic          pop;
  logic          drop_ack;
  logic [31:0]   redir_pc;
  logic [31:0]   next_pc;

  // The two low address bits of a redirect target carry no information.
  logic          unused_redir_lsb;
  assign unused_redir_lsb = ^REDIRECT_PC[1:0];

  assign redir_pc = {REDIRECT_PC[31:2], 2'b00};
  assign next_pc  = fetch_pc_q + 32'd4;

  // A redirect in the same cycle cancels the pop: the whole FIFO is flushed.
  assign pop = INST_VALID && INST_READY && !REDIRECT;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    drop_ack   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        mem_addr_d = fetch_pc_q;
        if (REDIRECT) begin
          fetch_pc_d = redir_pc;
        end else if (count_q < DEPTH_C) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (REDIRECT) begin
          fetch_pc_d = redir_pc;
          if (MEM_ACK) begin
            drop_ack   = 1'b1;
            mem_addr_d = redir_pc;
            state_d    = S_IDLE;
          end else begin
            // The in-flight request stays on the bus; its data is stale.
            state_d = S_DROP;
          end
        end else if (MEM_ACK) begin
          push       = 1'b1;
          fetch_pc_d = next_pc;
          mem_addr_d = next_pc;
          // This push fills the last free slot unless a pop frees one.
          if ((count_q == DEPTH_C - CW'(1)) && !pop) begin
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (REDIRECT) begin
          fetch_pc_d = redir_pc;
        end
        // The stale request finishes on its ACK even if another redirect
        // arrives in that cycle; holding DROP would issue a phantom request.
        if (MEM_ACK) begin
          drop_ack = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (REDIRECT) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: the outputs are gated by the occupancy count.
  always_ff @(posedge CLK) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= MEM_RDATA;
      pc_mem_q[wr_ptr_q]   <= mem_addr_q;
    end
  end

  assign MEM_REQ    = (state_q != S_IDLE);
  assign MEM_ADDR   = mem_addr_q;
  assign INST_VALID = (count_q != '0);
  assign INST       = INST_VALID ? inst_mem_q[rd_ptr_q] : 32'd0;
  assign INST_PC    = INST_VALID ? pc_mem_q[rd_ptr_q]   : 32'd0;
  assign COUNT      = count_q;

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetch_q, stat_fetch_d;
  logic [31:0] stat_disc_q, stat_disc_d;
  logic [CW:0] disc_inc;
  logic [32:0] disc_sum;

  always_comb begin
    stat_fetch_d = stat_fetch_q;
    if (push && (stat_fetch_q != '1)) begin
      stat_fetch_d = stat_fetch_q + 32'd1;
    end
    // Flushed valid entries plus any acknowledged word that is thrown away.
    disc_inc    = (REDIRECT ? {1'b0, count_q} : '0) + {{CW{1'b0}}, drop_ack};
    disc_sum    = {1'b0, stat_disc_q} + {{(32 - CW){1'b0}}, disc_inc};
    stat_disc_d = disc_sum[32] ? 32'hFFFF_FFFF : disc_sum[31:0];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stat_fetch_q <= '0;
      stat_disc_q  <= '0;
    end else begin
      stat_fetch_q <= stat_fetch_d;
      stat_disc_q  <= stat_disc_d;
    end
  end

  assign STAT_FETCHES  = stat_fetch_q;
  assign STAT_DISCARDS = stat_disc_q;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
//
// Directed bench for inst_fetch_queue (DEPTH=4, RESET_PC=0). The memory model
// returns MEM_ADDR ^ 32'hA5A5_0000; MEM_ACK is driven by the stimulus. Each
// scenario pushes the PCs it expects to see delivered into a queue; a monitor
// pops and compares on every accepted head (valid & ready, no redirect).
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic        CLK;
  logic        RST;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;
  logic        INST_VALID;
  logic [31:0] INST;
  logic [31:0] INST_PC;
  logic        INST_READY;
  logic [2:0]  COUNT;
`ifdef FETCH_STATS_EN
  logic [31:0] STAT_FETCHES;
  logic [31:0] STAT_DISCARDS;
`endif

  int          n_cmp;
  int          n_err;
  logic [31:0] exp_q[$];

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .MEM_REQ     (MEM_REQ),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_ACK     (MEM_ACK),
    .MEM_RDATA   (MEM_RDATA),
    .INST_VALID  (INST_VALID),
    .INST        (INST),
    .INST_PC     (INST_PC),
    .INST_READY  (INST_READY),
    .COUNT       (COUNT)
`ifdef FETCH_STATS_EN
    ,
    .STAT_FETCHES  (STAT_FETCHES),
    .STAT_DISCARDS (STAT_DISCARDS)
`endif
  );

  assign MEM_RDATA = MEM_ADDR ^ PAT;

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST         = 1'b0;
    REDIRECT    = 1'b0;
    REDIRECT_PC = 32'h0;
    MEM_ACK     = 1'b0;
    INST_READY  = 1'b0;
    tick();
    tick();
    RST = 1'b1;
  endtask

  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge CLK);
      if (RST && INST_VALID && INST_READY && !REDIRECT) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pop: got pc %h, expected no delivery (t=%0t)", INST_PC, $time);
        end else begin
          e = exp_q.pop_front();
          chk("head_pc", INST_PC, e);
          chk("head_inst", INST, e ^ PAT);
        end
      end
    end
  endtask

  task automatic expect_pcs(input logic [31:0] pcs[$]);
    foreach (pcs[i]) exp_q.push_back(pcs[i]);
  endtask

  task automatic chk_drained(input string name);
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    CLK   = 1'b0;
    n_cmp = 0;
    n_err = 0;
    fork
      monitor();
    join_none

    // Reset values
    RST = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = '0; MEM_ACK = 1'b0; INST_READY = 1'b0;
    tick();
    tick();
    chk("rst_mem_req",    32'(MEM_REQ),    32'd0);
    chk("rst_mem_addr",   MEM_ADDR,        32'h0);
    chk("rst_inst_valid", 32'(INST_VALID), 32'd0);
    chk("rst_inst",       INST,            32'h0);
    chk("rst_inst_pc",    INST_PC,         32'h0);
    chk("rst_count",      32'(COUNT),      32'd0);

    // 1: streaming with ACK and READY high
    MEM_ACK = 1'b1; INST_READY = 1'b1;
    expect_pcs('{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C});
    RST = 1'b1;
    chk("t1_req_before_first_edge", 32'(MEM_REQ), 32'd0);
    tick();
    chk("t1_req_rise",   32'(MEM_REQ),    32'd1);
    chk("t1_addr0",      MEM_ADDR,        32'h0);
    chk("t1_valid_low",  32'(INST_VALID), 32'd0);
    tick();
    chk("t1_valid_rise", 32'(INST_VALID), 32'd1);
    chk("t1_addr4",      MEM_ADDR,        32'h4);
    repeat (8) tick();
    INST_READY = 1'b0;
    chk_drained("t1_drained");

    // 2: backpressure fills the FIFO, then drains in order
    do_reset();
    MEM_ACK = 1'b1;
    repeat (7) tick();
    chk("t2_count_full", 32'(COUNT),   32'd4);
    chk("t2_req_low",    32'(MEM_REQ), 32'd0);
    chk("t2_addr_hold",  MEM_ADDR,     32'h10);
    expect_pcs('{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10});
    INST_READY = 1'b1;
    repeat (5) tick();
    INST_READY = 1'b0;
    chk_drained("t2_drained");

    // 3: delayed ACK with redirect in the first wait cycle
    do_reset();
    MEM_ACK = 1'b1; INST_READY = 1'b1;
    expect_pcs('{32'h000, 32'h100, 32'h104});
    repeat (3) tick();
    chk("t3_addr8", MEM_ADDR, 32'h8);
    MEM_ACK = 1'b0; REDIRECT = 1'b1; REDIRECT_PC = 32'h100;
    tick();
    REDIRECT = 1'b0;
    chk("t3_drop_req",   32'(MEM_REQ),    32'd1);
    chk("t3_drop_addr",  MEM_ADDR,        32'h8);
    chk("t3_flush_cnt",  32'(COUNT),      32'd0);
    chk("t3_flush_vld",  32'(INST_VALID), 32'd0);
    tick();
    chk("t3_hold_addr",  MEM_ADDR,        32'h8);
    MEM_ACK = 1'b1;
    tick();
    chk("t3_idle_req",   32'(MEM_REQ),    32'd0);
    tick();
    chk("t3_new_addr",   MEM_ADDR,        32'h100);
    chk("t3_new_req",    32'(MEM_REQ),    32'd1);
    repeat (3) tick();
    INST_READY = 1'b0;
    chk_drained("t3_drained");

    // 4: redirect coincident with ACK and pop at COUNT=2
    do_reset();
    MEM_ACK = 1'b1;
    repeat (3) tick();
    chk("t4_count2", 32'(COUNT), 32'd2);
    chk("t4_addr8",  MEM_ADDR,   32'h8);
    INST_READY = 1'b1; REDIRECT = 1'b1; REDIRECT_PC = 32'h100;
    expect_pcs('{32'h100});
    tick();
    REDIRECT = 1'b0;
    chk("t4_flush_cnt", 32'(COUNT),      32'd0);
    chk("t4_flush_vld", 32'(INST_VALID), 32'd0);
    chk("t4_idle_req",  32'(MEM_REQ),    32'd0);
    tick();
    chk("t4_new_addr",  MEM_ADDR,        32'h100);
    tick();
    tick();
    INST_READY = 1'b0;
    chk_drained("t4_drained");

    // 5: unaligned redirect target is word-aligned
    do_reset();
    tick();
    chk("t5_wait_addr", MEM_ADDR, 32'h0);
    REDIRECT = 1'b1; REDIRECT_PC = 32'h103;
    tick();
    REDIRECT = 1'b0; MEM_ACK = 1'b1;
    chk("t5_drop_addr", MEM_ADDR, 32'h0);
    tick();
    chk("t5_idle_req",  32'(MEM_REQ), 32'd0);
    tick();
    chk("t5_aligned",   MEM_ADDR, 32'h100);
    expect_pcs('{32'h100});
    INST_READY = 1'b1;
    tick();
    tick();
    INST_READY = 1'b0;
    chk_drained("t5_drained");

    // 6: asynchronous reset pulse mid-request with COUNT=3
    do_reset();
    MEM_ACK = 1'b1;
    repeat (4) tick();
    chk("t6_count3", 32'(COUNT),   32'd3);
    chk("t6_req",    32'(MEM_REQ), 32'd1);
    chk("t6_addrC",  MEM_ADDR,     32'hC);
    #2 RST = 1'b0;
    #1;
    chk("t6_async_req",   32'(MEM_REQ),    32'd0);
    chk("t6_async_addr",  MEM_ADDR,        32'h0);
    chk("t6_async_cnt",   32'(COUNT),      32'd0);
    chk("t6_async_vld",   32'(INST_VALID), 32'd0);
    chk("t6_async_inst",  INST,            32'h0);
    chk("t6_async_pc",    INST_PC,         32'h0);
    #4 RST = 1'b1;
    tick();
    chk("t6_resume_req",  32'(MEM_REQ), 32'd1);
    chk("t6_resume_addr", MEM_ADDR,     32'h0);
    expect_pcs('{32'h0, 32'h4});
    INST_READY = 1'b1;
    repeat (3) tick();
    INST_READY = 1'b0;
    chk_drained("t6_drained");

    // 7: fetch PC wraps from 0xFFFF_FFFC to 0
    do_reset();
    MEM_ACK = 1'b1;
    tick();
    REDIRECT = 1'b1; REDIRECT_PC = 32'hFFFF_FFF8;
    tick();
    REDIRECT = 1'b0;
    chk("t7_idle_req", 32'(MEM_REQ), 32'd0);
    chk("t7_cnt0",     32'(COUNT),   32'd0);
    tick();
    chk("t7_addr_f8",  MEM_ADDR,     32'hFFFF_FFF8);
    repeat (4) tick();
    chk("t7_count4",   32'(COUNT),   32'd4);
    chk("t7_addr_wrap", MEM_ADDR,    32'h8);
    expect_pcs('{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4});
    INST_READY = 1'b1;
    repeat (4) tick();
    INST_READY = 1'b0;
    chk_drained("t7_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
